calc_sequencer: RTL and testbench

// Clocked controller between the keypad decoder and a shared multi-cycle

---
 rtl/calc_sequencer.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : calc_sequencer
// Desc   : Keypad-driven calculator controller: builds decimal operands,
//          issues jobs to a shared multi-cycle ALU and drives the display.
// Rev    : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
    parameter int OPND_MAX = 999,
    parameter int TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic        op_start,
    output logic [1:0]  op_code,
    output logic [19:0] op_a,
    output logic [9:0]  op_b,
    input  logic        op_done,
    input  logic [19:0] op_result,
    input  logic        op_err,
    output logic [19:0] disp_num,
    output logic [2:0]  disp_sign,
    output logic        disp_err
);

    localparam int            TW          = $clog2(TIMEOUT + 1);
    localparam logic [13:0]   c_OPND_MAX  = 14'(OPND_MAX);
    localparam logic [TW-1:0] c_TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] c_TMO_ONE   = TW'(1);
    localparam logic [2:0]    c_SIGN_NONE = 3'b111;

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_OP_SEL  = 3'd1,
        S_ENTER_B = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4,
        S_DRAIN   = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    acc_q, acc_d;
    logic [19:0]   a_q, a_d;
    logic [9:0]    b_q, b_d;
    logic [1:0]    pend_q, pend_d;
    logic          chain_q, chain_d;
    logic [1:0]    chain_op_q, chain_op_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          start_q, start_d;
    logic [1:0]    opc_q, opc_d;
    logic [19:0]   opa_q, opa_d;
    logic [9:0]    opb_q, opb_d;
    logic [19:0]   num_q, num_d;
    logic [2:0]    sign_q, sign_d;
    logic          err_q, err_d;

    logic          w_key, w_digit, w_oper, w_clear, w_equal, w_tmo_hit;
    logic [1:0]    w_op;
    logic [2:0]    w_sign;
    logic [13:0]   w_acc_ext;
    logic [9:0]    w_acc_new;
    logic          w_issue, w_clr;

    // Codes 16-31 carry bit 4 and are never acted on.
    assign w_key     = key_valid & ~key_code[4];
    assign w_digit   = w_key & (key_code[3:0] <= 4'd9);
    assign w_oper    = w_key & (key_code[3:0] >= 4'd10) & (key_code[3:0] <= 4'd13);
    assign w_clear   = w_key & (key_code[3:0] == 4'd14);
    assign w_equal   = w_key & (key_code[3:0] == 4'd15);
    assign w_op      = key_code[1:0] ^ 2'b10;
    assign w_sign    = key_code[2:0] - 3'd2;
    assign w_acc_ext = {4'd0, acc_q} * 14'd10 + {10'd0, key_code[3:0]};
    assign w_acc_new = (w_acc_ext <= c_OPND_MAX) ? w_acc_ext[9:0] : acc_q;
    assign w_tmo_hit = (tmo_q >= c_TMO_LAST);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        pend_d     = pend_q;
        chain_d    = chain_q;
        chain_op_d = chain_op_q;
        tmo_d      = tmo_q;
        start_d    = 1'b0;
        opc_d      = opc_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        num_d      = num_q;
        sign_d     = sign_q;
        err_d      = err_q;
        w_issue    = 1'b0;
        w_clr      = 1'b0;

        case (state_q)
            S_ENTER_A: begin
                if (w_digit) begin
                    acc_d  = w_acc_new;
                    num_d  = {10'd0, w_acc_new};
                    sign_d = c_SIGN_NONE;
                end else if (w_oper) begin
                    a_d     = {10'd0, acc_q};
                    pend_d  = w_op;
                    acc_d   = '0;
                    sign_d  = w_sign;
                    state_d = S_OP_SEL;
                end else if (w_clear) begin
                    w_clr  = 1'b1;
                    sign_d = w_sign;
                end
            end
            S_OP_SEL: begin
                if (w_digit) begin
                    acc_d   = {6'd0, key_code[3:0]};
                    num_d   = {16'd0, key_code[3:0]};
                    sign_d  = c_SIGN_NONE;
                    state_d = S_ENTER_B;
                end else if (w_oper) begin
                    pend_d = w_op;
                    sign_d = w_sign;
                end else if (w_equal) begin
                    b_d     = a_q[9:0];
                    sign_d  = w_sign;
                    w_issue = 1'b1;
                end else if (w_clear) begin
                    w_clr  = 1'b1;
                    sign_d = w_sign;
                end
            end
            S_ENTER_B: begin
                if (w_digit) begin
                    acc_d  = w_acc_new;
                    num_d  = {10'd0, w_acc_new};
                    sign_d = c_SIGN_NONE;
                end else if (w_oper) begin
                    b_d        = acc_q;
                    chain_d    = 1'b1;
                    chain_op_d = w_op;
                    sign_d     = w_sign;
                    w_issue    = 1'b1;
                end else if (w_equal) begin
                    b_d     = acc_q;
                    sign_d  = w_sign;
                    w_issue = 1'b1;
                end else if (w_clear) begin
                    w_clr  = 1'b1;
                    sign_d = w_sign;
                end
            end
            S_EXEC: begin
                tmo_d = tmo_q + c_TMO_ONE;
                if (op_done) begin
                    if (w_clear) begin
                        w_clr  = 1'b1;
                        sign_d = w_sign;
                    end else if (op_err) begin
                        err_d   = 1'b1;
                        num_d   = '0;
                        chain_d = 1'b0;
                        state_d = S_ERR;
                    end else begin
                        a_d     = op_result;
                        num_d   = op_result;
                        chain_d = 1'b0;
                        if (chain_q) begin
                            pend_d  = chain_op_q;
                            acc_d   = '0;
                            state_d = S_OP_SEL;
                        end else begin
                            state_d = S_SHOW;
                        end
                    end
                end else if (w_clear) begin
                    sign_d = w_sign;
                    num_d  = '0;
                    if (w_tmo_hit) begin
                        w_clr = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (w_tmo_hit) begin
                    err_d   = 1'b1;
                    num_d   = '0;
                    chain_d = 1'b0;
                    state_d = S_ERR;
                end
            end
            S_SHOW: begin
                if (w_equal) begin
                    sign_d  = w_sign;
                    w_issue = 1'b1;
                end else if (w_oper) begin
                    pend_d  = w_op;
                    acc_d   = '0;
                    sign_d  = w_sign;
                    state_d = S_OP_SEL;
                end else if (w_digit) begin
                    acc_d   = {6'd0, key_code[3:0]};
                    num_d   = {16'd0, key_code[3:0]};
                    sign_d  = c_SIGN_NONE;
                    state_d = S_ENTER_A;
                end else if (w_clear) begin
                    w_clr  = 1'b1;
                    sign_d = w_sign;
                end
            end
            S_DRAIN: begin
                // The abandoned job still owns the ALU; wait it out before clearing.
                if (op_done || w_tmo_hit) begin
                    w_clr = 1'b1;
                end else begin
                    tmo_d = tmo_q + c_TMO_ONE;
                end
            end
            S_ERR: begin
                if (w_clear) begin
                    w_clr  = 1'b1;
                    sign_d = w_sign;
                end
            end
            default: state_d = S_ENTER_A;
        endcase

        if (w_clr) begin
            state_d = S_ENTER_A;
            acc_d   = '0;
            a_d     = '0;
            b_d     = '0;
            pend_d  = 2'b00;
            chain_d = 1'b0;
            num_d   = '0;
            err_d   = 1'b0;
        end
        // Job operands are captured only here, so they stay stable until op_done.
        if (w_issue) begin
            state_d = S_EXEC;
            start_d = 1'b1;
            tmo_d   = '0;
            opc_d   = pend_d;
            opa_d   = a_d;
            opb_d   = b_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ENTER_A;
            acc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            pend_q     <= 2'b00;
            chain_q    <= 1'b0;
            chain_op_q <= 2'b00;
            tmo_q      <= '0;
            start_q    <= 1'b0;
            opc_q      <= 2'b00;
            opa_q      <= '0;
            opb_q      <= '0;
            num_q      <= '0;
            sign_q     <= c_SIGN_NONE;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            pend_q     <= pend_d;
            chain_q    <= chain_d;
            chain_op_q <= chain_op_d;
            tmo_q      <= tmo_d;
            start_q    <= start_d;
            opc_q      <= opc_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            num_q      <= num_d;
            sign_q     <= sign_d;
            err_q      <= err_d;
        end
    end

    assign op_start  = start_q;
    assign op_code   = opc_q;
    assign op_a      = opa_q;
    assign op_b      = opb_q;
    assign disp_num  = num_q;
    assign disp_sign = sign_q;
    assign disp_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_calc_sequencer
// Desc   : Self-checking bench for calc_sequencer with an arithmetic reference.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;

    localparam int TIMEOUT = 4096;
    localparam int NV      = 15;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code  = '0;
    logic        op_done   = 1'b0;
    logic [19:0] op_result = '0;
    logic        op_err    = 1'b0;
    logic        op_start;
    logic [1:0]  op_code;
    logic [19:0] op_a;
    logic [9:0]  op_b;
    logic [19:0] disp_num;
    logic [2:0]  disp_sign;
    logic        disp_err;

    int total   = 0;
    int bad     = 0;
    int n_start = 0;

    calc_sequencer #(.OPND_MAX(999), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .op_start  (op_start),
        .op_code   (op_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_done   (op_done),
        .op_result (op_result),
        .op_err    (op_err),
        .disp_num  (disp_num),
        .disp_sign (disp_sign),
        .disp_err  (disp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (op_start) n_start <= n_start + 1;

    typedef struct {
        logic [4:0]  key;
        logic [19:0] num;
        logic [2:0]  sign;
        logic        start;
    } vec_t;

    vec_t tab [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte        c;
            logic [4:0] k;
            c = s[i];
            case (c)
                "+":     k = 5'd10;
                "-":     k = 5'd11;
                "*":     k = 5'd12;
                "/":     k = 5'd13;
                "C":     k = 5'd14;
                "=":     k = 5'd15;
                default: k = 5'(c - 8'd48);
            endcase
            press(k);
        end
    endtask

    task automatic alu_done(input logic [19:0] r, input logic e);
        op_done   = 1'b1;
        op_result = r;
        op_err    = e;
        tick();
        op_done   = 1'b0;
        op_result = '0;
        op_err    = 1'b0;
    endtask

    function automatic logic [19:0] alu_ref(input int code, input logic [19:0] a, input logic [9:0] b);
        longint x;
        longint y;
        longint z;
        x = longint'(a);
        y = longint'(b);
        case (code)
            0:       z = x + y;
            1:       z = x - y;
            2:       z = x * y;
            default: z = x / y;
        endcase
        return z[19:0];
    endfunction

    // Types 1-4 random digits and tracks the operand the keypad should have built.
    task automatic enter_rand(output logic [19:0] v);
        int n;
        int d;
        n = $urandom_range(1, 4);
        v = '0;
        for (int i = 0; i < n; i++) begin
            d = $urandom_range(0, 9);
            press(5'(d));
            if (int'(v) * 10 + d <= 999) v = 20'(int'(v) * 10 + d);
            chk("rnd digit num", disp_num, v);
        end
    endtask

    task automatic job(input int code, input logic [19:0] a, input logic [9:0] b,
                       output logic [19:0] r, output logic e);
        int lat;
        chk("job op_start", op_start, 1);
        chk("job op_code", op_code, code);
        chk("job op_a", op_a, a);
        chk("job op_b", op_b, b);
        e   = (code == 3) && (b == 10'd0);
        r   = e ? 20'd0 : alu_ref(code, a, b);
        lat = $urandom_range(0, 5);
        repeat (lat) tick();
        chk("job hold op_a", op_a, a);
        alu_done(e ? 20'hABCDE : r, e);
        if (e) begin
            chk("job err flag", disp_err, 1);
            chk("job err num", disp_num, 0);
        end else begin
            chk("job result num", disp_num, r);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s0;
        logic [19:0] r;
        logic        e;

        tab[0]  = '{5'd15, 20'd0,   3'd7, 1'b0};
        tab[1]  = '{5'd9,  20'd9,   3'd7, 1'b0};
        tab[2]  = '{5'd9,  20'd99,  3'd7, 1'b0};
        tab[3]  = '{5'd9,  20'd999, 3'd7, 1'b0};
        tab[4]  = '{5'd9,  20'd999, 3'd7, 1'b0};
        tab[5]  = '{5'd20, 20'd999, 3'd7, 1'b0};
        tab[6]  = '{5'd14, 20'd0,   3'd4, 1'b0};
        tab[7]  = '{5'd1,  20'd1,   3'd7, 1'b0};
        tab[8]  = '{5'd2,  20'd12,  3'd7, 1'b0};
        tab[9]  = '{5'd10, 20'd12,  3'd0, 1'b0};
        tab[10] = '{5'd11, 20'd12,  3'd1, 1'b0};
        tab[11] = '{5'd31, 20'd12,  3'd1, 1'b0};
        tab[12] = '{5'd3,  20'd3,   3'd7, 1'b0};
        tab[13] = '{5'd4,  20'd34,  3'd7, 1'b0};
        tab[14] = '{5'd15, 20'd34,  3'd5, 1'b1};

        #1 rst_n = 1'b0;
        #3;
        chk("rst op_start", op_start, 0);
        chk("rst op_code", op_code, 0);
        chk("rst op_a", op_a, 0);
        chk("rst op_b", op_b, 0);
        chk("rst disp_num", disp_num, 0);
        chk("rst disp_sign", disp_sign, 7);
        chk("rst disp_err", disp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            press(tab[i].key);
            chk($sformatf("vec%0d num", i), disp_num, tab[i].num);
            chk($sformatf("vec%0d sign", i), disp_sign, tab[i].sign);
            chk($sformatf("vec%0d start", i), op_start, tab[i].start);
        end
        chk("sub op_code", op_code, 1);
        chk("sub op_a", op_a, 12);
        chk("sub op_b", op_b, 34);
        press(5'd5);
        chk("busy key num", disp_num, 34);
        chk("busy op_start", op_start, 0);
        chk("busy op_a", op_a, 12);
        repeat (4) tick();
        alu_done(20'hFFFEA, 1'b0);
        chk("sub result", disp_num, 20'hFFFEA);
        chk("sub sign", disp_sign, 5);

        // 12 + 34 with a 5-cycle ALU, then repeated equals
        s0 = n_start;
        keys("C12+34=");
        chk("t1 op_start", op_start, 1);
        chk("t1 op_code", op_code, 0);
        chk("t1 op_a", op_a, 12);
        chk("t1 op_b", op_b, 34);
        tick();
        chk("t1 pulse end", op_start, 0);
        repeat (3) tick();
        alu_done(20'd46, 1'b0);
        chk("t1 num", disp_num, 46);
        chk("t1 sign", disp_sign, 5);
        chk("t1 pulses", n_start - s0, 1);
        press(5'd15);
        chk("t2 op_a 1", op_a, 46);
        chk("t2 op_b 1", op_b, 34);
        alu_done(20'd80, 1'b0);
        chk("t2 num 1", disp_num, 80);
        press(5'd15);
        chk("t2 op_a 2", op_a, 80);
        tick();
        alu_done(20'd114, 1'b0);
        chk("t2 num 2", disp_num, 114);

        // operand limit and chained operator
        keys("C9999");
        chk("t3 clamp", disp_num, 999);
        keys("C5*6+");
        chk("t3 start", op_start, 1);
        chk("t3 code", op_code, 2);
        chk("t3 op_a", op_a, 5);
        chk("t3 op_b", op_b, 6);
        tick();
        alu_done(20'd30, 1'b0);
        chk("t3 num", disp_num, 30);
        chk("t3 sign", disp_sign, 0);
        keys("7");
        chk("t3 b digit", disp_num, 7);
        keys("=");
        chk("t3 chain code", op_code, 0);
        chk("t3 chain op_a", op_a, 30);
        chk("t3 chain op_b", op_b, 7);
        alu_done(20'd37, 1'b0);
        chk("t3 chain num", disp_num, 37);

        // divide by zero
        keys("C7/0=");
        chk("t4 code", op_code, 3);
        chk("t4 op_b", op_b, 0);
        repeat (2) tick();
        alu_done(20'd0, 1'b1);
        chk("t4 err", disp_err, 1);
        chk("t4 err num", disp_num, 0);
        keys("3");
        chk("t4 digit ign err", disp_err, 1);
        chk("t4 digit ign num", disp_num, 0);
        keys("C");
        chk("t4 clr err", disp_err, 0);
        chk("t4 clr num", disp_num, 0);
        chk("t4 clr sign", disp_sign, 4);

        // clear while busy: late result discarded
        keys("C8*2=");
        s0 = n_start;
        tick();
        keys("C");
        chk("t5 clr sign", disp_sign, 4);
        chk("t5 clr num", disp_num, 0);
        repeat (2) tick();
        alu_done(20'd77, 1'b0);
        chk("t5 drop num", disp_num, 0);
        repeat (5) tick();
        chk("t5 drop num late", disp_num, 0);
        chk("t5 no restart", n_start - s0, 1);
        keys("4");
        chk("t5 new digit", disp_num, 4);
        keys("+1=");
        chk("t5 new op_a", op_a, 4);
        alu_done(20'd5, 1'b0);
        chk("t5 new num", disp_num, 5);

        // clear in the same cycle as op_done
        keys("C3*3=");
        tick();
        key_valid = 1'b1;
        key_code  = 5'd14;
        op_done   = 1'b1;
        op_result = 20'd55;
        tick();
        key_valid = 1'b0;
        key_code  = '0;
        op_done   = 1'b0;
        op_result = '0;
        chk("sim clr num", disp_num, 0);
        chk("sim clr sign", disp_sign, 4);
        keys("2+2=");
        chk("sim next op_a", op_a, 2);
        chk("sim next start", op_start, 1);
        alu_done(20'd4, 1'b0);

        // timeout, then async reset mid-job
        keys("C1+1=");
        repeat (TIMEOUT - 1) tick();
        chk("t6 tmo early", disp_err, 0);
        tick();
        chk("t6 tmo err", disp_err, 1);
        chk("t6 tmo num", disp_num, 0);
        keys("C5*6=");
        #2 rst_n = 1'b0;
        #1;
        chk("t6 arst op_start", op_start, 0);
        chk("t6 arst op_code", op_code, 0);
        chk("t6 arst op_a", op_a, 0);
        chk("t6 arst op_b", op_b, 0);
        chk("t6 arst disp_num", disp_num, 0);
        chk("t6 arst disp_sign", disp_sign, 7);
        chk("t6 arst disp_err", disp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        keys("3");
        chk("t6 after rst", disp_num, 3);

        // random sessions against the arithmetic reference
        for (int s = 0; s < 40; s++) begin
            logic [19:0] va;
            logic [19:0] vb;
            logic [19:0] r2;
            int          op1;
            int          op2;
            int          reps;
            press(5'd14);
            enter_rand(va);
            op1 = $urandom_range(0, 3);
            press(5'(10 + op1));
            enter_rand(vb);
            if ($urandom_range(0, 1) == 1) begin
                op2 = $urandom_range(0, 3);
                press(5'(10 + op2));
                job(op1, va, vb[9:0], r, e);
                if (e) continue;
                chk("rnd chain sign", disp_sign, op2);
                enter_rand(vb);
                press(5'd15);
                job(op2, r, vb[9:0], r2, e);
                op1 = op2;
                r   = r2;
            end else begin
                press(5'd15);
                job(op1, va, vb[9:0], r, e);
            end
            if (e) continue;
            chk("rnd eq sign", disp_sign, 5);
            reps = $urandom_range(0, 2);
            for (int k = 0; k < reps; k++) begin
                press(5'd15);
                job(op1, r, vb[9:0], r2, e);
                if (e) break;
                r = r2;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
